shared_ram_arb: RTL and testbench

SHARED_RAM_ARB -- requirements
Module: shared_ram_arb

---
 rtl/shared_ram_arb.sv | 160 ++++++++++++++++
 tb/tb_shared_ram_arb.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_ram_arb.sv
// Multi-channel arbiter in front of a single-port synchronous RAM: fixed-priority or round-robin grant.
// Define SHARED_RAM_ARB_AGE_EN to add per-channel wait counters that promote starved channels.
module shared_ram_arb #(
    parameter int NUM_CH   = 2,
    parameter int AW       = 12,
    parameter int DW       = 32,
    parameter int MODE     = 0,
    parameter int MAX_WAIT = 15
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CH-1:0]                  i_req,
    input  logic [NUM_CH*AW-1:0]               i_addr,
    input  logic [NUM_CH*DW-1:0]               i_wdata,
    input  logic [NUM_CH*(DW/8)-1:0]           i_wstrb,
    output logic [NUM_CH-1:0]                  o_gnt,
    output logic [NUM_CH-1:0]                  o_rvalid,
    output logic [DW-1:0]                      o_rdata,
    output logic                               o_ram_ce,
    output logic [AW-$clog2(DW/8)-1:0]         o_ram_addr,
    output logic [DW-1:0]                      o_ram_di,
    output logic [DW/8-1:0]                    o_ram_we,
    input  logic [DW-1:0]                      i_ram_do
);

    localparam int SL  = DW / 8;
    localparam int OFS = $clog2(SL);
    localparam int LW  = $clog2(NUM_CH);

    logic [LW-1:0]     last_gnt_q, last_gnt_d;
    logic [NUM_CH-1:0] rvalid_q, rvalid_d;
    logic [NUM_CH-1:0] is_wr;
    logic [NUM_CH-1:0] gnt_base;
    logic [NUM_CH-1:0] gnt_sel;
    logic [NUM_CH-1:0] gnt;
    logic              base_found;
    logic [AW-1:0]     addr_sel;
    logic [DW-1:0]     di_sel;
    logic [SL-1:0]     we_sel;
    logic              unused_addr;

    always_comb begin
        is_wr = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            is_wr[n] = |i_wstrb[n*SL +: SL];
        end
    end

    // Round-robin search begins one past the last granted channel, wrapping.
    always_comb begin
        gnt_base   = '0;
        base_found = 1'b0;
        if (MODE == 0) begin
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                if (!base_found && i_req[n]) begin
                    gnt_base[n] = 1'b1;
                    base_found  = 1'b1;
                end
            end
        end else begin
            for (int unsigned k = 1; k <= NUM_CH; k++) begin
                for (int unsigned n = 0; n < NUM_CH; n++) begin
                    if (!base_found && i_req[n] &&
                        (n == (32'(last_gnt_q) + k) % NUM_CH)) begin
                        gnt_base[n] = 1'b1;
                        base_found  = 1'b1;
                    end
                end
            end
        end
    end

`ifdef SHARED_RAM_ARB_AGE_EN
    logic [7:0]        wait_q [NUM_CH];
    logic [7:0]        wait_d [NUM_CH];
    logic [NUM_CH-1:0] urgent;
    logic [NUM_CH-1:0] gnt_urg;
    logic              urg_found;

    always_comb begin
        urgent    = '0;
        gnt_urg   = '0;
        urg_found = 1'b0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            urgent[n] = i_req[n] && (wait_q[n] == 8'(MAX_WAIT));
            if (!urg_found && urgent[n]) begin
                gnt_urg[n] = 1'b1;
                urg_found  = 1'b1;
            end
        end
        gnt_sel = urg_found ? gnt_urg : gnt_base;
    end

    // Counters saturate at the threshold so a starved channel stays urgent until served.
    always_comb begin
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            wait_d[n] = '0;
            if (i_req[n] && !gnt[n]) begin
                wait_d[n] = (wait_q[n] == 8'(MAX_WAIT)) ? wait_q[n] : wait_q[n] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                wait_q[n] <= '0;
            end
        end else begin
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                wait_q[n] <= wait_d[n];
            end
        end
    end
`else
    logic unused_max_wait;
    assign unused_max_wait = (MAX_WAIT != 0);
    assign gnt_sel         = gnt_base;
`endif

    assign gnt   = rst ? '0 : gnt_sel;
    assign o_gnt = gnt;

    always_comb begin
        addr_sel   = '0;
        di_sel     = '0;
        we_sel     = '0;
        last_gnt_d = last_gnt_q;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (gnt[n]) begin
                addr_sel   = i_addr[n*AW +: AW];
                di_sel     = i_wdata[n*DW +: DW];
                we_sel     = i_wstrb[n*SL +: SL];
                last_gnt_d = LW'(n);
            end
        end
    end

    assign rvalid_d    = gnt & ~is_wr;
    assign unused_addr = ^addr_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= LW'(NUM_CH - 1);
            rvalid_q   <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            rvalid_q   <= rvalid_d;
        end
    end

    // Gated as well as cleared so a read granted just before reset never reports.
    assign o_rvalid   = rst ? '0 : rvalid_q;
    assign o_rdata    = i_ram_do;
    assign o_ram_ce   = |gnt;
    assign o_ram_addr = addr_sel[AW-1:OFS];
    assign o_ram_di   = di_sel;
    assign o_ram_we   = we_sel;

endmodule

// File: tb/tb_shared_ram_arb.sv
// Scoreboard bench for shared_ram_arb: a fixed-priority and a round-robin instance share one stimulus.
// Aging expectations follow SHARED_RAM_ARB_AGE_EN when it is defined for the build.
module tb_shared_ram_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [35:0] addr = '0;
    logic [95:0] wdata = '0;
    logic [11:0] wstrb = '0;
    logic [31:0] ram_do = '0;

    logic [2:0]  fp_gnt, fp_rvalid, rr_gnt, rr_rvalid;
    logic [31:0] fp_rdata, rr_rdata, fp_di, rr_di;
    logic        fp_ce, rr_ce;
    logic [9:0]  fp_addr, rr_addr;
    logic [3:0]  fp_we, rr_we;

    logic [31:0] mem [1024];

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0]  rv;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    shared_ram_arb #(.NUM_CH(3), .AW(12), .DW(32), .MODE(0), .MAX_WAIT(3)) u_fp (
        .clk(clk), .rst(rst), .i_req(req), .i_addr(addr), .i_wdata(wdata), .i_wstrb(wstrb),
        .o_gnt(fp_gnt), .o_rvalid(fp_rvalid), .o_rdata(fp_rdata), .o_ram_ce(fp_ce),
        .o_ram_addr(fp_addr), .o_ram_di(fp_di), .o_ram_we(fp_we), .i_ram_do(ram_do)
    );

    shared_ram_arb #(.NUM_CH(3), .AW(12), .DW(32), .MODE(1), .MAX_WAIT(3)) u_rr (
        .clk(clk), .rst(rst), .i_req(req), .i_addr(addr), .i_wdata(wdata), .i_wstrb(wstrb),
        .o_gnt(rr_gnt), .o_rvalid(rr_rvalid), .o_rdata(rr_rdata), .o_ram_ce(rr_ce),
        .o_ram_addr(rr_addr), .o_ram_di(rr_di), .o_ram_we(rr_we), .i_ram_do(ram_do)
    );

    // Synchronous single-port RAM with byte enables, driven by the fixed-priority instance.
    always @(posedge clk) begin
        if (fp_ce) begin
            logic [31:0] m;
            m = {{8{fp_we[3]}}, {8{fp_we[2]}}, {8{fp_we[1]}}, {8{fp_we[0]}}};
            mem[fp_addr] <= (mem[fp_addr] & ~m) | (fp_di & m);
            ram_do       <= mem[fp_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_ch(input int ch, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        addr[ch*12 +: 12] = a;
        wdata[ch*32 +: 32] = d;
        wstrb[ch*4 +: 4]   = s;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        req   = 3'b111;
        wstrb = '1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (fp_gnt !== 3'b000) begin failures++; $display("FAIL reset_fp_gnt: got %b expected 000", fp_gnt); end
            checks++;
            if (rr_gnt !== 3'b000) begin failures++; $display("FAIL reset_rr_gnt: got %b expected 000", rr_gnt); end
            checks++;
            if (fp_ce !== 1'b0 || fp_we !== 4'b0000) begin
                failures++; $display("FAIL reset_ram_ctl: got ce=%b we=%b expected ce=0 we=0000", fp_ce, fp_we);
            end
            checks++;
            if (fp_rvalid !== 3'b000 || rr_rvalid !== 3'b000) begin
                failures++; $display("FAIL reset_rvalid: got fp=%b rr=%b expected 000", fp_rvalid, rr_rvalid);
            end
        end
        wstrb = '0;
    endtask

    task automatic test_fixed_priority();
        logic [2:0] reqs [9];
        logic [2:0] exps [9];
        exp_t e;
        reqs = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b000, 3'b110, 3'b100, 3'b101, 3'b011};
`ifdef SHARED_RAM_ARB_AGE_EN
        exps = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b000, 3'b010, 3'b100, 3'b001, 3'b001};
`else
        exps = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b010, 3'b100, 3'b001, 3'b001};
`endif
        do_reset();
        wstrb = '0;
        for (int i = 0; i < 9; i++) begin
            req = reqs[i];
            #1;
            checks++;
            if (fp_gnt !== exps[i]) begin
                failures++; $display("FAIL fixed_gnt[%0d]: req=%b got %b expected %b", i, reqs[i], fp_gnt, exps[i]);
            end
            checks++;
            if (fp_ce !== (|exps[i])) begin
                failures++; $display("FAIL fixed_ce[%0d]: got %b expected %b", i, fp_ce, |exps[i]);
            end
            sb_q.push_back('{rv: exps[i], data: 32'h0});
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            checks++;
            if (fp_rvalid !== e.rv) begin
                failures++; $display("FAIL fixed_rvalid[%0d]: got %b expected %b", i, fp_rvalid, e.rv);
            end
        end
        req = '0;
    endtask

    task automatic test_round_robin();
        logic [2:0] reqs [11];
        logic [2:0] exps [11];
        reqs = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b101, 3'b101, 3'b101, 3'b000, 3'b011};
        exps = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b100, 3'b001, 3'b000, 3'b010};
        do_reset();
        wstrb = '0;
        for (int i = 0; i < 11; i++) begin
            req = reqs[i];
            #1;
            checks++;
            if (rr_gnt !== exps[i] || rr_ce !== (|exps[i])) begin
                failures++; $display("FAIL rr_gnt[%0d]: req=%b got gnt=%b ce=%b expected gnt=%b", i, reqs[i], rr_gnt, rr_ce, exps[i]);
            end
            @(posedge clk);
            #1;
        end
        req = '0;
    endtask

    task automatic test_write_read();
        int          chs  [5];
        logic [11:0] as   [5];
        logic [31:0] ds   [5];
        logic [3:0]  ss   [5];
        logic [31:0] rexp [5];
        exp_t e;
        chs  = '{1, 0, 0, 0, 0};
        as   = '{12'h010, 12'h010, 12'h010, 12'h012, 12'h010};
        ds   = '{32'hDEADBEEF, 32'h0, 32'h11223344, 32'h00AA0000, 32'h0};
        ss   = '{4'b1111, 4'b0000, 4'b1111, 4'b0100, 4'b0000};
        rexp = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h11AA3344};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            logic [2:0] g;
            logic [9:0] wa;
            g  = 3'b001 << chs[i];
            wa = as[i][11:2];
            req = g;
            set_ch(chs[i], as[i], ds[i], ss[i]);
            #1;
            checks++;
            if (fp_gnt !== g) begin failures++; $display("FAIL wr_gnt[%0d]: got %b expected %b", i, fp_gnt, g); end
            checks++;
            if (fp_addr !== wa) begin failures++; $display("FAIL wr_ram_addr[%0d]: got %h expected %h", i, fp_addr, wa); end
            checks++;
            if (fp_we !== ss[i] || fp_di !== ds[i]) begin
                failures++; $display("FAIL wr_ram_data[%0d]: got we=%b di=%h expected we=%b di=%h", i, fp_we, fp_di, ss[i], ds[i]);
            end
            sb_q.push_back('{rv: (ss[i] == 4'b0000) ? g : 3'b000, data: rexp[i]});
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            checks++;
            if (fp_rvalid !== e.rv) begin failures++; $display("FAIL wr_rvalid[%0d]: got %b expected %b", i, fp_rvalid, e.rv); end
            if (e.rv != 3'b000) begin
                checks++;
                if (fp_rdata !== e.data) begin failures++; $display("FAIL wr_rdata[%0d]: got %h expected %h", i, fp_rdata, e.data); end
            end
        end
        req = '0;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  reqs [4];
        logic [2:0]  exps [4];
        logic [31:0] dat  [4];
        exp_t e;
        reqs = '{3'b011, 3'b010, 3'b010, 3'b000};
        exps = '{3'b001, 3'b010, 3'b010, 3'b000};
        dat  = '{32'h11AA3344, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0};
        req = 3'b010;
        set_ch(1, 12'h020, 32'hCAFEF00D, 4'b1111);
        @(posedge clk);
        #1;
        set_ch(0, 12'h010, 32'h0, 4'b0000);
        set_ch(1, 12'h020, 32'h0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            req = reqs[i];
            #1;
            checks++;
            if (fp_gnt !== exps[i]) begin failures++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", i, fp_gnt, exps[i]); end
            sb_q.push_back('{rv: exps[i], data: dat[i]});
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            checks++;
            if (fp_rvalid !== e.rv) begin failures++; $display("FAIL b2b_rvalid[%0d]: got %b expected %b", i, fp_rvalid, e.rv); end
            if (e.rv != 3'b000) begin
                checks++;
                if (fp_rdata !== e.data) begin failures++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", i, fp_rdata, e.data); end
            end
        end
        req = '0;
    endtask

    task automatic test_aging();
        logic [2:0] exps [6];
`ifdef SHARED_RAM_ARB_AGE_EN
        exps = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 3'b001};
`else
        exps = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
        do_reset();
        wstrb = '0;
        req   = 3'b011;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (fp_gnt !== exps[i]) begin failures++; $display("FAIL age_gnt[%0d]: got %b expected %b", i, fp_gnt, exps[i]); end
            @(posedge clk);
            #1;
        end
        req = '0;
    endtask

    task automatic test_reset_abort();
        do_reset();
        wstrb = '0;
        set_ch(2, 12'h020, 32'h0, 4'b0000);
        req = 3'b100;
        #1;
        checks++;
        if (fp_gnt !== 3'b100) begin failures++; $display("FAIL abort_gnt: got %b expected 100", fp_gnt); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 3'b111;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (fp_rvalid !== 3'b000 || rr_rvalid !== 3'b000) begin
                failures++; $display("FAIL abort_rvalid[%0d]: got fp=%b rr=%b expected 000", i, fp_rvalid, rr_rvalid);
            end
            checks++;
            if (fp_ce !== 1'b0 || fp_gnt !== 3'b000) begin
                failures++; $display("FAIL abort_ce[%0d]: got ce=%b gnt=%b expected ce=0 gnt=000", i, fp_ce, fp_gnt);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        checks++;
        if (fp_gnt !== 3'b001 || rr_gnt !== 3'b001) begin
            failures++; $display("FAIL abort_first_gnt: got fp=%b rr=%b expected 001", fp_gnt, rr_gnt);
        end
        checks++;
        if (fp_rvalid !== 3'b000) begin failures++; $display("FAIL abort_post_rvalid: got %b expected 000", fp_rvalid); end
        @(posedge clk);
        #1;
        req = '0;
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_write_read();
        test_back_to_back();
        test_aging();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
